pixel_fb_writer: RTL and testbench

//  Downstream of the quad-to-pixel serializer. Consumes the serial 8-bit R/G/B pixel stream
//  (valid_pix) and buffers it in a FIFO, since the serializer has no backpressure input.

---
 rtl/pixel_fb_writer_if.sv | 12 +
 rtl/pixel_fb_writer.sv | 166 ++++++++++++++++
 tb/tb_pixel_fb_writer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fb_writer_if.sv
// Framebuffer write port: address/data/write-enable with a ready handshake.
interface pixel_fb_writer_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              mem_ready;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_ready);
endinterface

// File: rtl/pixel_fb_writer.sv
// Buffers the serial RGB888 pixel stream, converts to RGB565 and writes it in raster order.
// Optional DITHER_EN: 2x2 ordered dither applied in the output-load stage.
module pixel_fb_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic [7:0]               R,
  input  logic [7:0]               G,
  input  logic [7:0]               B,
  input  logic                     valid_pix,
  pixel_fb_writer_if.master        mem,
  output logic                     frame_done,
  output logic                     overflow,
  output logic                     busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  logic              in_vld;
  logic [23:0]       in_rgb;
  logic [23:0]       fifo_mem [FIFO_DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic              xfer, pop, push, drop;
  logic [XW-1:0]     x, x_nxt;
  logic [YW-1:0]     y, y_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              frame_end;
  logic [15:0]       pix565;

  // Input sample stage; the FIFO write happens from here one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld <= 1'b0;
      in_rgb <= '0;
    end else begin
      in_vld <= valid_pix;
      in_rgb <= {R, G, B};
    end
  end

  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    xfer       = mem.mem_we & mem.mem_ready;
    pop        = !fifo_empty && (!mem.mem_we || xfer);
    push       = in_vld && (!fifo_full || pop);
    drop       = in_vld && !push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= in_rgb;
  end

  // Counters step on every transfer; a load in the same cycle uses the stepped position.
  always_comb begin
    x_nxt     = x;
    y_nxt     = y;
    addr_nxt  = addr;
    frame_end = 1'b0;
    if (xfer) begin
      if (x == X_LAST) begin
        x_nxt = '0;
        if (y == Y_LAST) begin
          y_nxt     = '0;
          addr_nxt  = '0;
          frame_end = 1'b1;
        end else begin
          y_nxt    = y + YW'(1);
          addr_nxt = addr + ADDR_W'(1);
        end
      end else begin
        x_nxt    = x + XW'(1);
        addr_nxt = addr + ADDR_W'(1);
      end
    end
  end

`ifdef DITHER_EN
  logic [1:0] dith;

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [2:0] inc);
    logic [8:0] s;
    s = {1'b0, c} + {6'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [15:0] to565(input logic [23:0] p, input logic [1:0] d);
    logic [7:0] r, g, b;
    r = sat_add(p[23:16], {d, 1'b0});
    g = sat_add(p[15:8],  {1'b0, d});
    b = sat_add(p[7:0],   {d, 1'b0});
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  // Pattern 0,2 / 3,1 over (y[0],x[0]) reduces to d = {y^x, y}.
  always_comb begin
    dith   = {y_nxt[0] ^ x_nxt[0], y_nxt[0]};
    pix565 = to565(fifo_mem[rd_ptr[PW-1:0]], dith);
  end
`else
  function automatic logic [15:0] to565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  always_comb pix565 = to565(fifo_mem[rd_ptr[PW-1:0]]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x             <= '0;
      y             <= '0;
      addr          <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
    end else if (frame_start) begin
      x             <= '0;
      y             <= '0;
      addr          <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      x          <= x_nxt;
      y          <= y_nxt;
      addr       <= addr_nxt;
      frame_done <= frame_end;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        mem.mem_we    <= 1'b1;
        mem.mem_addr  <= addr_nxt;
        mem.mem_wdata <= pix565;
      end else if (xfer) begin
        mem.mem_we <= 1'b0;
      end
    end
  end

  assign busy = !fifo_empty || mem.mem_we;
endmodule

// File: tb/tb_pixel_fb_writer.sv
// Scoreboard bench for pixel_fb_writer: a full-size instance and a 4x2 instance for frame wrap.
module tb_pixel_fb_writer;
  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [7:0] R, G, B;
  logic       valid_a, valid_b;
  logic       frame_done_a, overflow_a, busy_a;
  logic       frame_done_b, overflow_b, busy_b;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned fd_count = 0;
  logic        fd_pending = 1'b0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        ea, eb;

  pixel_fb_writer_if #(.ADDR_W(19)) mem_a ();
  pixel_fb_writer_if #(.ADDR_W(3))  mem_b ();

  pixel_fb_writer #(.H_RES(640), .V_RES(480), .ADDR_W(19), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .R(R), .G(G), .B(B),
    .valid_pix(valid_a), .mem(mem_a), .frame_done(frame_done_a),
    .overflow(overflow_a), .busy(busy_a)
  );

  pixel_fb_writer #(.H_RES(4), .V_RES(2), .ADDR_W(3), .FIFO_DEPTH(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .R(R), .G(G), .B(B),
    .valid_pix(valid_b), .mem(mem_b), .frame_done(frame_done_b),
    .overflow(overflow_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [23:0] p);
    {R, G, B} = p;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [23:0] p);
    {R, G, B} = p;
    valid_b = 1'b1;
    step();
    valid_b = 1'b0;
  endtask

  task automatic expect_a(input logic [18:0] a, input logic [15:0] d);
    q_a.push_back({a, d});
  endtask

  task automatic expect_b(input logic [18:0] a, input logic [15:0] d);
    q_b.push_back({a, d});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (q_a.size() != 0 || q_b.size() != 0); i++) step();
    check(name, 32'(q_a.size() + q_b.size()), 32'd0);
    repeat (5) step();
  endtask

  // Pixel whose RGB565 form is {i,i,i}; low bits are zero so dither never carries into it.
  function automatic logic [23:0] pat(input int i);
    return {8'(i * 8), 8'(i * 4), 8'(i * 8)};
  endfunction

  function automatic logic [15:0] pat565(input int i);
    return {5'(i), 6'(i), 5'(i)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && mem_a.mem_we && mem_a.mem_ready) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write_a: actual addr=%0h data=%0h required no write",
                 mem_a.mem_addr, mem_a.mem_wdata);
      end else begin
        ea = q_a.pop_front();
        check("addr_a", 32'(mem_a.mem_addr), 32'(ea.addr));
        check("data_a", 32'(mem_a.mem_wdata), 32'(ea.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done_b || fd_pending) check("frame_done_b", 32'(frame_done_b), 32'(fd_pending));
      if (frame_done_b) fd_count++;
      fd_pending = 1'b0;
      if (mem_b.mem_we && mem_b.mem_ready) begin
        if (q_b.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write_b: actual addr=%0h data=%0h required no write",
                   mem_b.mem_addr, mem_b.mem_wdata);
        end else begin
          eb = q_b.pop_front();
          check("addr_b", 32'(mem_b.mem_addr), 32'(eb.addr));
          check("data_b", 32'(mem_b.mem_wdata), 32'(eb.data));
          if (eb.addr == 19'd7) fd_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    {R, G, B} = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    mem_a.mem_ready = 1'b1;
    mem_b.mem_ready = 1'b1;
    repeat (3) step();
    check("rst_we", 32'(mem_a.mem_we), 32'd0);
    check("rst_addr", 32'(mem_a.mem_addr), 32'd0);
    check("rst_data", 32'(mem_a.mem_wdata), 32'd0);
    check("rst_fd", 32'(frame_done_a), 32'd0);
    check("rst_ovf", 32'(overflow_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    step();

    // Primary colours plus white.
    expect_a(19'd0, 16'hF800);
    expect_a(19'd1, 16'h07E0);
    expect_a(19'd2, 16'h001F);
    expect_a(19'd3, 16'hFFFF);
    send_a(24'hFF0000);
    send_a(24'h00FF00);
    send_a(24'h0000FF);
    send_a(24'hFFFFFF);
    drain("drain_quad");
    check("busy_idle", 32'(busy_a), 32'd0);

    // Asynchronous reset with a write stalled on the port.
    mem_a.mem_ready = 1'b0;
    send_a(24'hAAAAAA);
    send_a(24'hBBBBBB);
    send_a(24'hCCCCCC);
    step();
    check("stall_we", 32'(mem_a.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_we", 32'(mem_a.mem_we), 32'd0);
    check("async_addr", 32'(mem_a.mem_addr), 32'd0);
    check("async_data", 32'(mem_a.mem_wdata), 32'd0);
    check("async_busy", 32'(busy_a), 32'd0);
    q_a.delete();
    step();
    rst_n = 1'b1;
    mem_a.mem_ready = 1'b1;
    step();
    expect_a(19'd0, 16'h11AA);
    send_a(24'h123456);
    drain("drain_after_rst");

    // FIFO overflow: 1 in the output register + 16 buffered, 3 dropped.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    mem_a.mem_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i <= 17) expect_a(19'(i - 1), pat565(i));
      send_a(pat(i));
    end
    repeat (3) step();
    check("ovf_set", 32'(overflow_a), 32'd1);
    check("stall_addr", 32'(mem_a.mem_addr), 32'd0);
    check("stall_data", 32'(mem_a.mem_wdata), 32'h0821);
    check("stall_busy", 32'(busy_a), 32'd1);
    mem_a.mem_ready = 1'b1;
    drain("drain_ovf");
    check("ovf_sticky", 32'(overflow_a), 32'd1);

    // frame_start after 5 of 10 pixels; the 6th arrives in the frame_start cycle.
    mem_a.mem_ready = 1'b0;
    for (int j = 21; j <= 25; j++) send_a(pat(j));
    repeat (2) step();
    check("ovf_before_fs", 32'(overflow_a), 32'd1);
    for (int j = 26; j <= 30; j++) expect_a(19'(j - 26), pat565(j));
    frame_start = 1'b1;
    send_a(pat(26));
    frame_start = 1'b0;
    check("fs_we", 32'(mem_a.mem_we), 32'd0);
    check("fs_ovf", 32'(overflow_a), 32'd0);
    mem_a.mem_ready = 1'b1;
    for (int j = 27; j <= 30; j++) send_a(pat(j));
    drain("drain_fs");
    check("ovf_after_fs", 32'(overflow_a), 32'd0);

    // 4x2 frame wrap on the small instance.
    for (int k = 1; k <= 9; k++) expect_b(19'((k - 1) % 8), pat565(k));
    for (int k = 1; k <= 9; k++) send_b(pat(k));
    drain("drain_wrap");
    check("fd_count", fd_count, 32'd1);

    // Conversion at x=1,y=0 (dither d=2 when enabled), plus two-cycle latency.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    expect_a(19'd0, 16'h0000);
`ifdef DITHER_EN
    expect_a(19'd1, 16'h0821);
`else
    expect_a(19'd1, 16'h0020);
`endif
    send_a(24'h000000);
    send_a(24'h040404);
    check("latency_k1", 32'(mem_a.mem_we), 32'd0);
    step();
    check("latency_k2", 32'(mem_a.mem_we), 32'd1);
    drain("drain_dither");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
